// File: rtl/hbm_txn_limiter_pkg.sv
// Shared types for the HBM transaction limiter: joined AXI request/response
// structs, limiter FSM states and the outstanding-count width.
package hbm_pd_pkg;

  localparam int unsigned CntWidth = 8;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    DRAINED
  } lim_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_join_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_join_rsp_t;

endpackage

// File: rtl/hbm_txn_limiter_if.sv
// Joined AXI bus bundle (request + response structs) with master/slave views.
interface hbm_txn_limiter_if
  import hbm_pd_pkg::*;
#(
  parameter type req_t = axi_join_req_t,
  parameter type rsp_t = axi_join_rsp_t
);
  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/hbm_txn_limiter_counter.sv
// Saturating-safe outstanding transaction counter; simultaneous inc/dec
// leaves the count unchanged, and a wrap attempt is flagged by assertion.
module hbm_txn_counter
  import hbm_pd_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic [CntWidth-1:0] max_i,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [CntWidth-1:0] count_q, count_d;

  assign full_o  = (count_q >= max_i);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && !inc_i && empty_o));
  assert property (@(posedge clk_i) disable iff (rst_i) !(inc_i && !dec_i && full_o));

endmodule

// File: rtl/hbm_txn_limiter.sv
// Limits outstanding AW/AR toward the HBM model and supports drain requests.
// Optional stall statistics are enabled by defining HBM_TXN_LIMITER_STATS_EN.
module hbm_txn_limiter #(
  parameter int unsigned MaxReads  = 8,
  parameter int unsigned MaxWrites = 8,
  parameter type axi_req_t = hbm_pd_pkg::axi_join_req_t,
  parameter type axi_rsp_t = hbm_pd_pkg::axi_join_rsp_t
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  axi_req_t                        slv_req_i,
  output axi_rsp_t                        slv_rsp_o,
  output axi_req_t                        mst_req_o,
  input  axi_rsp_t                        mst_rsp_i,
  input  logic                            drain_i,
  output logic                            drained_o,
  output logic [hbm_pd_pkg::CntWidth-1:0] rd_cnt_o,
  output logic [hbm_pd_pkg::CntWidth-1:0] wr_cnt_o
`ifdef HBM_TXN_LIMITER_STATS_EN
  ,
  output logic [31:0]                     aw_stall_o,
  output logic [31:0]                     ar_stall_o
`endif
);
  import hbm_pd_pkg::*;

  lim_state_e state_q, state_d;
  logic wr_full, wr_empty, rd_full, rd_empty;
  logic aw_open, ar_open;
  logic aw_hs, ar_hs, b_hs, rlast_hs;

  assign aw_open = (state_q == ACTIVE) && !wr_full;
  assign ar_open = (state_q == ACTIVE) && !rd_full;

  // Everything passes through untouched except the AW/AR valid/ready gates.
  always_comb begin
    mst_req_o          = slv_req_i;
    slv_rsp_o          = mst_rsp_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_open;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_open;
  end

  assign aw_hs    = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
  assign ar_hs    = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
  assign b_hs     = mst_rsp_i.b_valid & slv_req_i.b_ready;
  assign rlast_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

  hbm_txn_counter u_wr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .max_i   (CntWidth'(MaxWrites)),
    .count_o (wr_cnt_o),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  hbm_txn_counter u_rd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ar_hs),
    .dec_i   (rlast_hs),
    .max_i   (CntWidth'(MaxReads)),
    .count_o (rd_cnt_o),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE:  if (drain_i) state_d = DRAIN;
      DRAIN: begin
        if (!drain_i) begin
          state_d = ACTIVE;
        end else if (wr_empty && rd_empty) begin
          state_d = DRAINED;
        end
      end
      DRAINED: if (!drain_i) state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  assign drained_o = (state_q == DRAINED);

`ifdef HBM_TXN_LIMITER_STATS_EN
  logic [31:0] aw_stall_q, aw_stall_d, ar_stall_q, ar_stall_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    aw_stall_d = aw_stall_q;
    ar_stall_d = ar_stall_q;
    if (slv_req_i.aw_valid && !aw_open) aw_stall_d = sat_inc(aw_stall_q);
    if (slv_req_i.ar_valid && !ar_open) ar_stall_d = sat_inc(ar_stall_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_stall_q <= '0;
      ar_stall_q <= '0;
    end else begin
      aw_stall_q <= aw_stall_d;
      ar_stall_q <= ar_stall_d;
    end
  end

  assign aw_stall_o = aw_stall_q;
  assign ar_stall_o = ar_stall_q;
`endif

endmodule

// File: tb/tb_hbm_txn_limiter.sv
// Directed table-driven bench for hbm_txn_limiter (MaxWrites=2, MaxReads=4).
module tb_hbm_txn_limiter;
  import hbm_pd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drain = 1'b0;
  logic drained;
  logic [7:0] rd_cnt, wr_cnt;
`ifdef HBM_TXN_LIMITER_STATS_EN
  logic [31:0] aw_stall, ar_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hbm_txn_limiter_if slv_bus ();
  hbm_txn_limiter_if mst_bus ();

  hbm_txn_limiter #(.MaxReads(4), .MaxWrites(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_bus.req),
    .slv_rsp_o (slv_bus.rsp),
    .mst_req_o (mst_bus.req),
    .mst_rsp_i (mst_bus.rsp),
    .drain_i   (drain),
    .drained_o (drained),
    .rd_cnt_o  (rd_cnt),
    .wr_cnt_o  (wr_cnt)
`ifdef HBM_TXN_LIMITER_STATS_EN
    ,
    .aw_stall_o (aw_stall),
    .ar_stall_o (ar_stall)
`endif
  );

  logic       c_inc = 1'b0, c_dec = 1'b0;
  logic [7:0] c_cnt;
  logic       c_full, c_empty;

  hbm_txn_counter u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (c_inc),
    .dec_i   (c_dec),
    .max_i   (8'd2),
    .count_o (c_cnt),
    .full_o  (c_full),
    .empty_o (c_empty)
  );

  // inputs: awv awr bv br arv arr rv rlast rr drain
  // expect: mst_awv slv_awr mst_arv slv_arr, wr_cnt, rd_cnt, drained
  typedef struct packed {
    logic [9:0] in;
    logic [3:0] gate;
    logic [7:0] wr;
    logic [7:0] rd;
    logic       dr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    slv_bus.req.aw_valid  = v.in[9];
    mst_bus.rsp.aw_ready  = v.in[8];
    mst_bus.rsp.b_valid   = v.in[7];
    slv_bus.req.b_ready   = v.in[6];
    slv_bus.req.ar_valid  = v.in[5];
    mst_bus.rsp.ar_ready  = v.in[4];
    mst_bus.rsp.r_valid   = v.in[3];
    mst_bus.rsp.r.last    = v.in[2];
    slv_bus.req.r_ready   = v.in[1];
    drain                 = v.in[0];
    #1;
    check($sformatf("v%0d_gates", idx),
          {28'd0, mst_bus.req.aw_valid, slv_bus.rsp.aw_ready, mst_bus.req.ar_valid, slv_bus.rsp.ar_ready},
          {28'd0, v.gate});
    check($sformatf("v%0d_wr_cnt", idx), {24'd0, wr_cnt}, {24'd0, v.wr});
    check($sformatf("v%0d_rd_cnt", idx), {24'd0, rd_cnt}, {24'd0, v.rd});
    check($sformatf("v%0d_drained", idx), {31'd0, drained}, {31'd0, v.dr});
  endtask

  task automatic idle_inputs();
    slv_bus.req = '0;
    mst_bus.rsp = '0;
    drain = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1;
    check("rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    check("rst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
    check("rst_drained", {31'd0, drained}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back AWs against MaxWrites=2, then B releases one slot
    vecs.push_back({10'b11_00_00_000_0, 4'b1100, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b11_00_00_000_0, 4'b1100, 8'd1, 8'd0, 1'b0});
    vecs.push_back({10'b11_00_00_000_0, 4'b0000, 8'd2, 8'd0, 1'b0});
    vecs.push_back({10'b11_11_00_000_0, 4'b0000, 8'd2, 8'd0, 1'b0});
    vecs.push_back({10'b11_00_00_000_0, 4'b1100, 8'd1, 8'd0, 1'b0});
    // full with AW and B presented together, then both handshaking together
    vecs.push_back({10'b11_11_00_000_0, 4'b0000, 8'd2, 8'd0, 1'b0});
    vecs.push_back({10'b11_11_00_000_0, 4'b1100, 8'd1, 8'd0, 1'b0});
    vecs.push_back({10'b00_11_00_000_0, 4'b0000, 8'd1, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_00_000_0, 4'b0000, 8'd0, 8'd0, 1'b0});
    // AR len 3: one stalled last beat, three non-last beats, then rlast
    vecs.push_back({10'b00_00_11_000_0, 4'b0011, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_00_110_0, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b00_00_00_101_0, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b00_00_00_101_0, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b00_00_00_101_0, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b00_00_00_111_0, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b00_00_00_000_0, 4'b0000, 8'd0, 8'd0, 1'b0});
    // drain with one read and one write outstanding
    vecs.push_back({10'b11_00_11_000_0, 4'b1111, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_00_000_1, 4'b0000, 8'd1, 8'd1, 1'b0});
    vecs.push_back({10'b11_00_11_000_1, 4'b0000, 8'd1, 8'd1, 1'b0});
    vecs.push_back({10'b11_11_11_000_1, 4'b0000, 8'd1, 8'd1, 1'b0});
    vecs.push_back({10'b11_00_11_111_1, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b11_00_11_000_1, 4'b0000, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b11_00_11_000_1, 4'b0000, 8'd0, 8'd0, 1'b1});
    vecs.push_back({10'b11_00_11_000_0, 4'b0000, 8'd0, 8'd0, 1'b1});
    vecs.push_back({10'b11_00_11_000_0, 4'b1111, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_11_00_111_0, 4'b0000, 8'd1, 8'd1, 1'b0});
    // drain dropped before DRAINED, re-raised, then full drain cycle
    vecs.push_back({10'b00_00_00_000_1, 4'b0000, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_00_000_0, 4'b0000, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_11_000_1, 4'b0011, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_00_111_1, 4'b0000, 8'd0, 8'd1, 1'b0});
    vecs.push_back({10'b00_00_00_000_1, 4'b0000, 8'd0, 8'd0, 1'b0});
    vecs.push_back({10'b00_00_00_000_1, 4'b0000, 8'd0, 8'd0, 1'b1});
    vecs.push_back({10'b00_00_00_000_0, 4'b0000, 8'd0, 8'd0, 1'b1});
    vecs.push_back({10'b00_00_00_000_0, 4'b0000, 8'd0, 8'd0, 1'b0});

    foreach (vecs[i]) apply(vecs[i], i);

    // payload passthrough
    @(negedge clk);
    idle_inputs();
    slv_bus.req.aw.addr = 32'hDEAD_BEEF;
    slv_bus.req.w.data  = 32'h1234_5678;
    mst_bus.rsp.r.data  = 32'hCAFE_F00D;
    mst_bus.rsp.b.resp  = 2'b10;
    #1;
    check("pass_aw_addr", mst_bus.req.aw.addr, 32'hDEAD_BEEF);
    check("pass_w_data", mst_bus.req.w.data, 32'h1234_5678);
    check("pass_r_data", slv_bus.rsp.r.data, 32'hCAFE_F00D);
    check("pass_b_resp", {30'd0, slv_bus.rsp.b.resp}, 32'd2);

    // async reset with three reads outstanding
    idle_inputs();
    slv_bus.req.ar_valid = 1'b1;
    mst_bus.rsp.ar_ready = 1'b1;
    repeat (3) @(negedge clk);
    idle_inputs();
    #1;
    check("pre_rst_rd_cnt", {24'd0, rd_cnt}, 32'd3);
    slv_bus.req.ar_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
    check("async_rst_drained", {31'd0, drained}, 32'd0);
    check("async_rst_active", {31'd0, mst_bus.req.ar_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // async reset out of DRAINED
    drain = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_drained", {31'd0, drained}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_clears_drained", {31'd0, drained}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drain = 1'b0;

    // counter: inc+dec while full holds the count
    c_inc = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("cnt_full_val", {24'd0, c_cnt}, 32'd2);
    check("cnt_full_flag", {31'd0, c_full}, 32'd1);
    c_dec = 1'b1;
    @(negedge clk);
    #1;
    check("cnt_incdec_full", {24'd0, c_cnt}, 32'd2);
    c_inc = 1'b0;
    repeat (2) @(negedge clk);
    c_dec = 1'b0;
    #1;
    check("cnt_empty_val", {24'd0, c_cnt}, 32'd0);
    check("cnt_empty_flag", {31'd0, c_empty}, 32'd1);

`ifdef HBM_TXN_LIMITER_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("stall_rst", ar_stall, 32'd0);
    drain = 1'b1;
    @(negedge clk);
    slv_bus.req.ar_valid = 1'b1;
    repeat (5) @(negedge clk);
    slv_bus.req.ar_valid = 1'b0;
    #1;
    check("ar_stall_5", ar_stall, 32'd5);
    check("aw_stall_0", aw_stall, 32'd0);
    drain = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hbm_txn_limiter.md
HBM_TXN_LIMITER -- requirements
Module: hbm_txn_limiter

Interface
REQ-001 SHALL have parameter MaxReads, default 8, giving the maximum outstanding AR transactions (range 1..255).
REQ-002 SHALL have parameter MaxWrites, default 8, giving the maximum outstanding AW transactions (range 1..255).
REQ-003 SHALL have type parameters axi_req_t and axi_rsp_t, defaults the joined AXI request and response types, for the joined AXI bus.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port slv_req_i, input, axi_req_t: requests from the narrow/wide join.
REQ-007 SHALL have port slv_rsp_o, output, axi_rsp_t: responses to the join.
REQ-008 SHALL have port mst_req_o, output, axi_req_t: requests to the HBM model.
REQ-009 SHALL have port mst_rsp_i, input, axi_rsp_t: responses from the HBM model.
REQ-010 SHALL have port drain_i, input, 1 bit: level request to stop accepting new AW/AR.
REQ-011 SHALL have port drained_o, output, 1 bit: draining is complete and no transactions are outstanding.
REQ-012 SHALL have ports rd_cnt_o and wr_cnt_o, output, 8 bits each: the current outstanding read and write counts.

Function
REQ-013 SHALL pass W, R and B channels and all payload fields combinationally, with zero latency and no modification.
REQ-014 SHALL forward AW valid/ready only while wr_cnt < MaxWrites and the state is ACTIVE; otherwise mst aw_valid=0 and slv aw_ready=0.
REQ-015 SHALL gate AR the same way, using rd_cnt < MaxReads.
REQ-016 SHALL increment wr_cnt on an AW handshake and decrement it on a B handshake; both in one cycle leaves the count unchanged.
REQ-017 SHALL increment rd_cnt on an AR handshake and decrement it on an R handshake with rlast=1; both in one cycle leaves the count unchanged.
REQ-018 SHALL never wrap the counters; a decrement at zero or an increment at the maximum is an assertion failure.
REQ-019 SHALL use three FSM states, ACTIVE, DRAIN and DRAINED, with reset state ACTIVE.
REQ-020 SHALL move ACTIVE->DRAIN when drain_i=1; the first blocked AW/AR is the one presented in the following cycle.
REQ-021 SHALL move DRAIN->DRAINED when rd_cnt==0 and wr_cnt==0 (registered); if the counters are already zero it transitions one cycle after entering DRAIN.
REQ-022 SHALL move DRAIN or DRAINED->ACTIVE when drain_i=0, and return to DRAIN if drain_i=1 again before DRAINED.
REQ-023 SHALL assert drained_o only in DRAINED.
REQ-024 SHALL keep an AW/AR valid that is already asserted upstream held and pending (not dropped) while it is gated.

Reset
REQ-025 SHALL on rst_i set state=ACTIVE, rd_cnt=0, wr_cnt=0, drained_o=0 and statistics counters=0.
REQ-026 SHALL, when rst_i is asserted mid-transaction, clear all counts immediately; the HBM model is reset in the same domain.

Configuration
REQ-027 SHALL, with HBM_TXN_LIMITER_STATS_EN defined, add outputs aw_stall_o and ar_stall_o (32 bits each).
REQ-028 SHALL increment each stall counter in every cycle where upstream valid=1 and the channel is gated, saturating at all-ones.
REQ-029 SHALL, without HBM_TXN_LIMITER_STATS_EN, omit the stall ports and logic entirely.

Structure
REQ-030 SHALL place the FSM state enum and counter width constant (8) in hbm_pd_pkg.
REQ-031 SHALL implement both counters with one sub-module, hbm_txn_counter (inc, dec, max, count, full, empty), instantiated twice.
REQ-032 SHALL sit between floo_narrow_wide_join and floo_hbm_model in the HBM test node.

Verification
REQ-033 SHALL cover: MaxWrites=2, three back-to-back AWs with B held -> third AW stalls, wr_cnt_o=2; one B -> third accepted next cycle.
REQ-034 SHALL cover: AR of burst len 3 -> rd_cnt_o=1 until the 4th R beat with rlast, then 0; non-last beats leave the count at 1.
REQ-035 SHALL cover: wr_cnt=2 (full) with simultaneous AW and B handshakes -> wr_cnt stays 2, no assertion.
REQ-036 SHALL cover: drain_i raised with 1 read and 1 write outstanding -> new AR/AW blocked; drained_o=1 one cycle after both complete; drain_i low -> ACTIVE, traffic resumes.
REQ-037 SHALL cover: rst_i pulsed with 3 reads outstanding -> rd_cnt_o=0, state ACTIVE, drained_o=0 asynchronously.
REQ-038 SHALL cover, with HBM_TXN_LIMITER_STATS_EN: AR gated for 5 cycles -> ar_stall_o=5.
